// File: rtl/btn_debounce.sv
// Pushbutton front-end: two-flop synchroniser on the raw active-low button,
// a four-state debounce FSM driven by a stability counter, and registered
// one-cycle press / release / long-press pulses plus a clean level output.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int CNT_WIDTH         = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 btn_sync;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                 long_done_q, long_done_d;
    logic                 btn_level_q, btn_level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;

    // Two-flop synchroniser; resets to "released" so no phantom press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_sync = ~sync2_q;

    // Debounce FSM: a candidate edge must hold for DEBOUNCE_CYCLES before it is accepted.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        btn_level_d = btn_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_sync) begin
                    state_d  = S_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = S_PRESSED;
                    btn_level_d = 1'b1;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!btn_sync) begin
                    state_d  = S_RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (!long_done_q && (hold_cnt_q == HOLD_LAST)) begin
                    // Counter stops here; long_done keeps the pulse to one per press.
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else if (!long_done_q) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                // hold_cnt is frozen here so a rejected release bounce resumes the hold timing.
                if (btn_sync) begin
                    state_d = S_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = S_IDLE;
                    btn_level_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                db_cnt_d    = '0;
                hold_cnt_d  = '0;
                long_done_d = 1'b0;
                btn_level_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn_level        = btn_level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule
